button_conditioner: RTL and testbench

Front-end conditioner for the three clock-control push-buttons (minute, second, reset: `msr[2:0]`). It synchronises the raw pad inputs, debounces each one independently, and produces a clean level plus a single-cycle press pulse per button. Its outputs feed the `msr` inputs of the button encoder, which drives the mm:ss counter and the 7-segment display path.

---
 rtl/button_conditioner.sv | 112 +++++++++++
 tb/tb_button_conditioner.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Three-channel push-button front end: 2-flop synchroniser, per-channel debouncer, press strobe.
// Define BUTTON_AUTO_REPEAT_EN to add per-channel auto-repeat pulses while a button is held.
module button_conditioner #(
    parameter int unsigned DB_CNT        = 1_000_000,
    parameter int unsigned REPEAT_DELAY  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] msr_raw,
    output logic [2:0] msr_level,
    output logic [2:0] msr_pulse
);

    localparam int unsigned DB_W = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CNT - 1);

    if (DB_CNT < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_params
        $error("button_conditioner: DB_CNT, REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
    end

    logic [2:0]      sync1_q, sync2_q;
    logic [DB_W-1:0] db_cnt_q [3];
    logic [DB_W-1:0] db_cnt_d [3];
    logic [2:0]      level_d, pulse_d, press;

    // A change is accepted only after DB_CNT consecutive cycles of disagreement with the level.
    always_comb begin
        level_d = msr_level;
        press   = '0;
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != msr_level[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    level_d[i] = ~msr_level[i];
                    press[i]   = ~msr_level[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;
    localparam logic [RP_W-1:0] DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);

    logic [RP_W-1:0] rp_cnt_q [3];
    logic [RP_W-1:0] rp_cnt_d [3];
    logic [2:0]      rp_armed_q, rp_armed_d, repeat_fire;

    // The counter keeps its cadence even when a fire is masked by a pending release.
    always_comb begin
        rp_armed_d  = '0;
        repeat_fire = '0;
        for (int i = 0; i < 3; i++) begin
            rp_cnt_d[i] = '0;
            if (msr_level[i]) begin
                rp_armed_d[i] = rp_armed_q[i];
                if (rp_cnt_q[i] == (rp_armed_q[i] ? PERIOD_LAST : DELAY_LAST)) begin
                    rp_armed_d[i]  = 1'b1;
                    repeat_fire[i] = (sync2_q[i] == msr_level[i]);
                end else begin
                    rp_cnt_d[i] = rp_cnt_q[i] + RP_W'(1);
                end
            end
        end
        pulse_d = press | repeat_fire;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rp_armed_q <= '0;
            for (int i = 0; i < 3; i++) begin
                rp_cnt_q[i] <= '0;
            end
        end else begin
            rp_armed_q <= rp_armed_d;
            for (int i = 0; i < 3; i++) begin
                rp_cnt_q[i] <= rp_cnt_d[i];
            end
        end
    end
`else
    always_comb begin
        pulse_d = press;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            msr_level <= '0;
            msr_pulse <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= msr_raw;
            sync2_q   <= sync1_q;
            msr_level <= level_d;
            msr_pulse <= pulse_d;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised bench for button_conditioner against a sliding-window reference model.
// Repeat pulses are modelled only when BUTTON_AUTO_REPEAT_EN is defined.
module tb_button_conditioner;

    localparam int unsigned DB = 4;
    localparam int unsigned RD = 10;
    localparam int unsigned RP = 3;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic [2:0] msr_raw = 3'b000;
    logic [2:0] msr_level, msr_pulse;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .DB_CNT       (DB),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .msr_raw  (msr_raw),
        .msr_level(msr_level),
        .msr_pulse(msr_pulse)
    );

    // Model: raw delayed by two samples, then a level flips once the last DB
    // delayed samples all disagree with it.
    logic [2:0] m_s1, m_s2, m_lvl, m_pulse;
    logic [2:0] m_win [DB];
`ifdef BUTTON_AUTO_REPEAT_EN
    int m_age [3];
`endif

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%b want=%b", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_s1    = '0;
        m_s2    = '0;
        m_lvl   = '0;
        m_pulse = '0;
        for (int j = 0; j < DB; j++) m_win[j] = '0;
`ifdef BUTTON_AUTO_REPEAT_EN
        for (int i = 0; i < 3; i++) m_age[i] = 0;
`endif
    endtask

    task automatic model_edge(input logic [2:0] raw);
        logic [2:0] seen;
        logic       all_diff;
        seen = m_s2;
        for (int j = DB - 1; j > 0; j--) m_win[j] = m_win[j-1];
        m_win[0] = seen;
        m_s2     = m_s1;
        m_s1     = raw;
        m_pulse  = '0;
        for (int i = 0; i < 3; i++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DB; j++) if (m_win[j][i] == m_lvl[i]) all_diff = 1'b0;
            if (all_diff) begin
                m_lvl[i] = ~m_lvl[i];
                if (m_lvl[i]) begin
                    m_pulse[i] = 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
                    m_age[i] = 0;
`endif
                end
            end else if (m_lvl[i]) begin
`ifdef BUTTON_AUTO_REPEAT_EN
                m_age[i]++;
                if (m_age[i] >= RD && (m_age[i] - RD) % RP == 0 && seen[i] == m_lvl[i])
                    m_pulse[i] = 1'b1;
`endif
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (reset) model_edge(msr_raw);
        check("level", msr_level, m_lvl);
        check("pulse", msr_pulse, m_pulse);
    endtask

    task automatic hold(input logic [2:0] v, input int n);
        msr_raw = v;
        repeat (n) step();
    endtask

    task automatic pulse_reset(input int n);
        reset = 1'b0;
        model_reset();
        #1;
        check("rst_level", msr_level, m_lvl);
        check("rst_pulse", msr_pulse, m_pulse);
        repeat (n) step();
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        #1 reset = 1'b0;
        #1;
        check("init_level", msr_level, m_lvl);
        check("init_pulse", msr_pulse, m_pulse);
        #11 reset = 1'b1;

        // Clean press and release on bit 0
        hold(3'b000, 3);
        hold(3'b001, 10);
        hold(3'b000, 10);
        // Bounce on bit 1, then settle high
        for (int k = 0; k < 5; k++) begin
            hold(3'b010, 2);
            hold(3'b000, 2);
        end
        hold(3'b010, 12);
        hold(3'b000, 10);
        // Simultaneous press on bits 0 and 2, then release bit 0 only
        hold(3'b101, 10);
        hold(3'b100, 10);
        hold(3'b000, 10);
        // Reset mid-debounce with button held
        hold(3'b001, 3);
        pulse_reset(2);
        hold(3'b001, 10);
        hold(3'b000, 10);
        // Long hold for auto-repeat
        hold(3'b001, 30);
        hold(3'b000, 12);

        for (int s = 0; s < 80; s++) begin
            logic [2:0] v;
            int         n;
            v = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) n = $urandom_range(1, DB + 1);
            else                           n = $urandom_range(DB + 3, 35);
            hold(v, n);
            if ($urandom_range(0, 9) == 0) pulse_reset($urandom_range(1, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
